// File: rtl/imem_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_fetch_ctrl_pkg
// Brief  : Shared types and constants for the instruction fetch controller.
// Rev    : 1.0  initial release
// ============================================================================
package imem_fetch_ctrl_pkg;

  // Fetch controller operating modes
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } fetch_state_t;

  localparam int          IMEM_ADDR_W      = 7;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  localparam logic [31:0] NOP_INST         = 32'h8000_0000;

  // One prefetch buffer entry: instruction word plus the PC it came from
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : imem_fetch_ctrl_if
// Brief  : Memory, loader, redirect and decode-side signals of the fetch
//          controller. master = fetch controller, slave = its environment.
// Rev    : 1.0  initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic [31:0]       imem_addr;
  logic [31:0]       imem_data;
  logic              imem_wr_en;
  logic [31:0]       imem_wr_data;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_gnt;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_valid;
  logic              inst_ready;

  modport master (
    output imem_addr, imem_wr_en, imem_wr_data, ld_gnt,
    output inst, inst_pc, inst_valid,
    input  imem_data, ld_req, ld_addr, ld_data,
    input  redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, imem_wr_en, imem_wr_data, ld_gnt,
    input  inst, inst_pc, inst_valid,
    output imem_data, ld_req, ld_addr, ld_data,
    output redirect, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module : imem_fetch_ctrl_fetch_buf
// Brief  : Small synchronous FIFO of {inst, pc} entries with flush.
//          Caller never pops when empty nor pushes when full without a pop.
// Rev    : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl_fetch_buf
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     r_store [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage needs no reset: occupancy gates every use of it
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) r_store[r_wr_ptr] <= push_data;
  end

  assign head  = r_store[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : imem_fetch_ctrl
// Brief  : Instruction fetch sequencer and loader arbiter for a single-port,
//          combinational-read instruction memory, feeding decode through a
//          small prefetch buffer.
// Rev    : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_run;
  logic             w_granted;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_flush;

  // Outputs are forced quiet while rst is high so a reset landing in a
  // granted cycle cannot leak a write into memory.
  assign w_run     = (r_state == ST_RUN);
  assign w_granted = !rst && (r_state == ST_LOAD) && bus.ld_req;
  assign w_valid   = !rst && (w_count != '0);
  assign w_pop     = w_valid && bus.inst_ready;
  // A pending loader or redirect suppresses the fetch in that cycle
  assign w_push    = w_run && !bus.ld_req && !bus.redirect &&
                     ((w_count < CNT_W'(BUF_DEPTH)) || w_pop);
  assign w_flush   = w_run && (bus.ld_req || bus.redirect);

  assign w_push_entry = '{inst: bus.imem_data, pc: r_pc};

  // Mode and PC sequencing; the loader takes priority over a redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ld_req) begin
            r_state <= ST_LOAD;
          end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
          end else if (w_push) begin
            r_pc <= r_pc + 32'd1;
          end
        end
        ST_LOAD: begin
          if (!bus.ld_req) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  imem_fetch_ctrl_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (w_flush),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count)
  );

  assign bus.imem_addr    = rst       ? 32'd0 :
                            w_granted ? {{(32-ADDR_W){1'b0}}, bus.ld_addr} : r_pc;
  assign bus.imem_wr_en   = w_granted;
  assign bus.imem_wr_data = w_granted ? bus.ld_data : 32'd0;
  assign bus.ld_gnt       = w_granted;
  assign bus.inst_valid   = w_valid;
  assign bus.inst         = w_valid ? w_head.inst : 32'd0;
  assign bus.inst_pc      = w_valid ? w_head.pc   : 32'd0;

endmodule
`default_nettype wire
